// File: rtl/scan_key_pkg.sv
// Shared types for the scan key transmitter.
// Widths default here when the build does not predefine them.
`ifndef SCAN_KEY_WIDTH
`define SCAN_KEY_WIDTH 32
`endif
`ifndef SCAN_KEY_NUMBER
`define SCAN_KEY_NUMBER 8
`endif

package scan_key_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE,
    S_FAIL
  } state_e;

  localparam int WAIT_CYCLES_DEF = 4;

endpackage

// File: rtl/scan_key_store.sv
// Key word register file: one write port, one combinational read port.
// clr_i wipes every word in a single cycle.
module scan_key_store
  import scan_key_pkg::*;
#(
  parameter int W  = 32,
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          clr_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] key_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) key_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < N; i++) key_q[i] <= '0;
    end else if (wr_en_i && (32'(wr_addr_i) < N)) begin
      key_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (32'(rd_idx_i) < N) rd_data_o = key_q[rd_idx_i];
  end

endmodule

// File: rtl/scan_key_transmitter.sv
// Streams the stored key sequence to vim_scan_control and tracks unlock.
// Define SCAN_KEY_ZEROIZE_EN to wipe the key store on entry to DONE.
`ifndef SCAN_KEY_WIDTH
`define SCAN_KEY_WIDTH 32
`endif
`ifndef SCAN_KEY_NUMBER
`define SCAN_KEY_NUMBER 8
`endif

module scan_key_transmitter
  import scan_key_pkg::*;
#(
  parameter int SCAN_KEY_WIDTH  = `SCAN_KEY_WIDTH,
  parameter int SCAN_KEY_NUMBER = `SCAN_KEY_NUMBER,
  parameter int WAIT_CYCLES     = WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_wr_en,
  input  logic [$clog2(SCAN_KEY_NUMBER)-1:0] key_wr_addr,
  input  logic [SCAN_KEY_WIDTH-1:0] key_wr_data,
  input  logic start,
  input  logic scan_unlock,
  output logic [SCAN_KEY_WIDTH-1:0] scan_key,
  output logic scan_key_valid,
  output logic busy,
  output logic done,
  output logic fail
);

  localparam int AW = $clog2(SCAN_KEY_NUMBER);
  localparam int IW = AW + 1;
  localparam logic [IW-1:0] LAST  = IW'(SCAN_KEY_NUMBER - 1);
  localparam logic [7:0]    WLAST = 8'(WAIT_CYCLES - 1);

  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic idle_like, wr_ok, clr;
  logic [SCAN_KEY_WIDTH-1:0] rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idle_like = (state_q == S_IDLE) || (state_q == S_FAIL);

  // Unlock wins over everything except the terminal state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_FAIL: begin
        if (scan_unlock) begin
          state_d = S_DONE;
        end else if (start) begin
          state_d = S_SEND;
          idx_d   = '0;
        end
      end
      S_SEND: begin
        if (scan_unlock) begin
          state_d = S_DONE;
        end else if (idx_q == LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_WAIT: begin
        if (scan_unlock) begin
          state_d = S_DONE;
        end else if (cnt_q == WLAST) begin
          state_d = S_FAIL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_ok = key_wr_en && idle_like;

`ifdef SCAN_KEY_ZEROIZE_EN
  assign clr = (state_d == S_DONE) && (state_q != S_DONE);
`else
  assign clr = 1'b0;
`endif

  scan_key_store #(
    .W  (SCAN_KEY_WIDTH),
    .N  (SCAN_KEY_NUMBER),
    .AW (AW)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_ok),
    .wr_addr_i (key_wr_addr),
    .wr_data_i (key_wr_data),
    .clr_i     (clr),
    .rd_idx_i  (idx_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  assign scan_key_valid = (state_q == S_SEND);
  assign scan_key = scan_key_valid ? rd_data : '0;
  assign busy = (state_q == S_SEND) || (state_q == S_WAIT);
  assign done = (state_q == S_DONE);
  assign fail = (state_q == S_FAIL);

endmodule

// File: tb/tb_scan_key_transmitter.sv
// Directed bench for scan_key_transmitter with a paired receiver model.
// Build with SCAN_KEY_ZEROIZE_EN to expect a wiped store after unlock.
module tb_scan_key_transmitter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_wr_en = 1'b0;
  logic [2:0] key_wr_addr = '0;
  logic [31:0] key_wr_data = '0;
  logic start = 1'b0;
  logic scan_unlock = 1'b0;
  logic [31:0] scan_key;
  logic scan_key_valid, busy, done, fail;

  int total = 0;
  int bad = 0;

  logic [31:0] gold [8];
  logic [31:0] rx_exp [8];
  int rx_cnt = 0;
  bit rx_bad = 1'b0;
  int nvalid = 0;

  always #5 clk = ~clk;

  scan_key_transmitter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_wr_en      (key_wr_en),
    .key_wr_addr    (key_wr_addr),
    .key_wr_data    (key_wr_data),
    .start          (start),
    .scan_unlock    (scan_unlock),
    .scan_key       (scan_key),
    .scan_key_valid (scan_key_valid),
    .busy           (busy),
    .done           (done),
    .fail           (fail)
  );

  // Receiver: accepts matching words in order, unlocks one cycle after the last.
  always @(negedge clk) begin
    if (rst_n) begin
      if (scan_key_valid) nvalid++;
      if (rx_cnt == 8) begin
        scan_unlock = 1'b1;
      end else if (scan_key_valid && !rx_bad) begin
        if (scan_key == rx_exp[rx_cnt]) rx_cnt++;
        else rx_bad = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input logic [2:0] a, input logic [31:0] d);
    key_wr_en   = 1'b1;
    key_wr_addr = a;
    key_wr_data = d;
    step();
    key_wr_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] w3);
    for (int i = 0; i < 8; i++)
      wr_key(3'(i), (i == 3) ? w3 : gold[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic rx_reset();
    rx_cnt = 0;
    rx_bad = 1'b0;
    scan_unlock = 1'b0;
    for (int i = 0; i < 8; i++) rx_exp[i] = gold[i];
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic dut_reset();
    rst_n = 1'b0;
    rx_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  int n;
  int nv;

  initial begin
    gold[0] = 32'hEF012345; gold[1] = 32'h6789ABCD;
    gold[2] = 32'hEF012345; gold[3] = 32'h7891ABCD;
    gold[4] = 32'h3D4E5F60; gold[5] = 32'hFF8A0B2C;
    gold[6] = 32'hFA1BC49D; gold[7] = 32'h87A5E932;
    rx_reset();

    #1;
    chk("rst_key", scan_key, 32'h0);
    chk("rst_valid", 32'(scan_key_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Normal unlock
    load(gold[3]);
    pulse_start();
    chk("a_first", scan_key, 32'hEF012345);
    chk("a_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("a_latency", 32'(n), 32'd9);
    chk("a_done", 32'(done), 32'd1);
    chk("a_busy_end", 32'(busy), 32'd0);
    chk("a_rxcnt", 32'(rx_cnt), 32'd8);
    chk("a_rxbad", 32'(rx_bad), 32'd0);

    // Corrupted word 3 times out
    dut_reset();
    load(32'h0);
    pulse_start();
    repeat (7) step();
    chk("b_word7", scan_key, 32'h87A5E932);
    step();
    chk("b_wait_busy", 32'(busy), 32'd1);
    chk("b_wait_valid", 32'(scan_key_valid), 32'd0);
    chk("b_wait_key", scan_key, 32'h0);
    repeat (3) step();
    chk("b_pre_fail", 32'(fail), 32'd0);
    step();
    chk("b_fail", 32'(fail), 32'd1);
    chk("b_fail_busy", 32'(busy), 32'd0);
    chk("b_rxbad", 32'(rx_bad), 32'd1);

    // Repair and retry from FAIL; write during SEND is dropped
    wr_key(3'd3, 32'h7891ABCD);
    chk("c_fail_hold", 32'(fail), 32'd1);
    rx_reset();
    pulse_start();
    chk("c_fail_clr", 32'(fail), 32'd0);
    chk("c_valid", 32'(scan_key_valid), 32'd1);
    chk("c_first", scan_key, 32'hEF012345);
    step();
    wr_key(3'd5, 32'hDEADBEEF);
    wait_done(n);
    chk("c_done", 32'(done), 32'd1);
    chk("c_rxbad", 32'(rx_bad), 32'd0);

    // Reset in the middle of SEND
    dut_reset();
    chk("d_store_clr", dut.u_store.key_q[3], 32'h0);
    load(gold[3]);
    pulse_start();
    repeat (4) step();
    chk("d_word4", scan_key, 32'h3D4E5F60);
    nv = nvalid;
    rst_n = 1'b0;
    #1;
    chk("d_key", scan_key, 32'h0);
    chk("d_valid", 32'(scan_key_valid), 32'd0);
    chk("d_busy", 32'(busy), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("d_no_words", 32'(nvalid), 32'(nv));
    chk("d_idle_busy", 32'(busy), 32'd0);

    // Write and start together; start during SEND ignored
    rx_reset();
    for (int i = 1; i < 8; i++) wr_key(3'(i), gold[i]);
    rx_exp[0] = 32'h12345678;
    key_wr_en   = 1'b1;
    key_wr_addr = 3'd0;
    key_wr_data = 32'h12345678;
    start = 1'b1;
    step();
    key_wr_en = 1'b0;
    start = 1'b0;
    chk("e_first", scan_key, 32'h12345678);
    step();
    pulse_start();
    chk("e_no_restart", scan_key, 32'hEF012345);
    wait_done(n);
    chk("e_done", 32'(done), 32'd1);
    chk("e_rxcnt", 32'(rx_cnt), 32'd8);
    pulse_start();
    step();
    chk("e_done_hold", 32'(done), 32'd1);
    chk("e_done_busy", 32'(busy), 32'd0);
`ifdef SCAN_KEY_ZEROIZE_EN
    chk("e_store0", dut.u_store.key_q[0], 32'h0);
    chk("e_store7", dut.u_store.key_q[7], 32'h0);
`else
    chk("e_store0", dut.u_store.key_q[0], 32'h12345678);
    chk("e_store7", dut.u_store.key_q[7], 32'h87A5E932);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
